vai_rx_tag_demux: RTL

VAI_RX_TAG_DEMUX -- requirements
Module: vai_rx_tag_demux

---
 rtl/vai_rx_tag_demux_if.sv | 40 ++++
 rtl/vai_rx_tag_demux.sv | 107 ++++++++++
 2 files changed

// File: rtl/vai_rx_tag_demux_if.sv
// Bus bundle for the Rx tag demux: Tx tag-allocation requests, upstream Rx
// responses and the restored per-AFU response stream.
interface vai_rx_tag_demux_if #(
    parameter int NUM_SUB_AFUS = 15,
    parameter int TAG_W        = 6,
    parameter int PAYLOAD_W    = 512
);
    // Requests are held by the issuer while req_ready is low; there is no
    // other backpressure.  Responses are accepted every cycle unconditionally.
    logic                    req_valid;
    logic [3:0]              req_afu_id;
    logic [15:0]             req_mdata;
    logic [1:0]              req_cl_len;
    logic                    req_ready;
    logic [TAG_W-1:0]        req_tag;

    logic                    rsp_valid;
    logic [15:0]             rsp_mdata;
    logic [1:0]              rsp_cl_num;
    logic [PAYLOAD_W-1:0]    rsp_payload;

    logic [NUM_SUB_AFUS-1:0] out_valid;
    logic [15:0]             out_mdata;
    logic [1:0]              out_cl_num;
    logic [PAYLOAD_W-1:0]    out_payload;

    modport slave (
        input  req_valid, req_afu_id, req_mdata, req_cl_len,
        output req_ready, req_tag,
        input  rsp_valid, rsp_mdata, rsp_cl_num, rsp_payload,
        output out_valid, out_mdata, out_cl_num, out_payload
    );

    modport master (
        output req_valid, req_afu_id, req_mdata, req_cl_len,
        input  req_ready, req_tag,
        output rsp_valid, rsp_mdata, rsp_cl_num, rsp_payload,
        input  out_valid, out_mdata, out_cl_num, out_payload
    );
endinterface

// File: rtl/vai_rx_tag_demux.sv
// Tag table that swaps sub-AFU mdata for a shared tag on Tx and restores it,
// routing each Rx response back to its issuing sub-AFU one cycle later.
module vai_rx_tag_demux #(
    parameter int NUM_SUB_AFUS = 15,
    parameter int TAG_W        = 6,
    parameter int PAYLOAD_W    = 512
) (
    input  logic                pClk,
    input  logic                SoftReset_n,
    vai_rx_tag_demux_if.slave   bus,
    output logic [TAG_W:0]      inflight,
    output logic                err_unexpected,
    output logic                err_bad_id
);
    localparam int DEPTH = 2 ** TAG_W;

    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [3:0]              afu_q   [DEPTH];
    logic [15:0]             mdata_q [DEPTH];
    logic [1:0]              len_q   [DEPTH];
    logic [2:0]              cnt_q   [DEPTH];

    logic [TAG_W:0]          inflight_q, inflight_d;
    logic [NUM_SUB_AFUS-1:0] out_valid_q;
    logic [15:0]             out_mdata_q;
    logic [1:0]              out_cl_num_q;
    logic [PAYLOAD_W-1:0]    out_payload_q;
    logic                    err_unexp_q, err_bad_q;

    logic [TAG_W-1:0]        free_tag;
    logic [TAG_W-1:0]        rsp_tag;
    logic                    id_ok, alloc, bad_id, hit, last;

    always_comb begin
        free_tag = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_tag = TAG_W'(i);
        end
    end

    assign rsp_tag = bus.rsp_mdata[TAG_W-1:0];
    assign id_ok   = (int'(bus.req_afu_id) < NUM_SUB_AFUS);
    assign alloc   = bus.req_valid & bus.req_ready & id_ok;
    assign bad_id  = bus.req_valid & ~id_ok;
    assign hit     = bus.rsp_valid & valid_q[rsp_tag];
    // The response that completes the burst frees its entry at the same edge.
    assign last    = hit & (cnt_q[rsp_tag] == {1'b0, len_q[rsp_tag]});

    // Alloc picks an invalid entry and free hits a valid one, so they never collide.
    always_comb begin
        valid_d = valid_q;
        if (alloc) valid_d[free_tag] = 1'b1;
        if (last)  valid_d[rsp_tag]  = 1'b0;
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({alloc, last})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge pClk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            valid_q       <= '0;
            inflight_q    <= '0;
            out_valid_q   <= '0;
            out_mdata_q   <= '0;
            out_cl_num_q  <= '0;
            out_payload_q <= '0;
            err_unexp_q   <= 1'b0;
            err_bad_q     <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            inflight_q    <= inflight_d;
            out_valid_q   <= hit ? (NUM_SUB_AFUS'(1) << afu_q[rsp_tag]) : '0;
            if (hit) out_mdata_q <= mdata_q[rsp_tag];
            out_cl_num_q  <= bus.rsp_cl_num;
            out_payload_q <= bus.rsp_payload;
            err_unexp_q   <= bus.rsp_valid & ~valid_q[rsp_tag];
            err_bad_q     <= bad_id;
        end
    end

    // Entry contents are qualified by valid_q, so they need no reset.
    always_ff @(posedge pClk) begin
        if (alloc) begin
            afu_q[free_tag]   <= bus.req_afu_id;
            mdata_q[free_tag] <= bus.req_mdata;
            len_q[free_tag]   <= bus.req_cl_len;
            cnt_q[free_tag]   <= 3'd0;
        end
        if (hit) cnt_q[rsp_tag] <= cnt_q[rsp_tag] + 3'd1;
    end

    assign bus.req_ready   = ~&valid_q;
    assign bus.req_tag     = free_tag;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_mdata   = out_mdata_q;
    assign bus.out_cl_num  = out_cl_num_q;
    assign bus.out_payload = out_payload_q;
    assign inflight        = inflight_q;
    assign err_unexpected  = err_unexp_q;
    assign err_bad_id      = err_bad_q;
endmodule
